// File: rtl/bubble_sort_engine.sv
// In-place bubble sorter: N entries of W bits, serial load, one compare/swap per cycle.
// Optional swap counter output enabled by defining BUBBLE_SORT_STATS_EN.
module bubble_sort_engine #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned SW = (N > 1) ? $clog2(N * (N - 1) / 2 + 1) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_valid,
  input  logic [W-1:0]   load_data,
  input  logic           start,
  input  logic           descending,
  output logic           busy,
  output logic           done,
  output logic           sorted,
  output logic [PW-1:0]  wr_ptr,
`ifdef BUBBLE_SORT_STATS_EN
  output logic [SW-1:0]  swap_count,
`endif
  output logic [N*W-1:0] data_out
);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   mem [N];
  logic [PW-1:0]  i, j, jn;
  logic           mode, flag;
  logic [W-1:0]   cur_c, nxt_c;
  logic           load_c, accept_c, swap_c, last_c, fin_c;

  // Operand pair at the current compare index.
  if (N > 1) begin : g_cmp
    always_comb begin
      jn    = j + PW'(1);
      cur_c = mem[j];
      nxt_c = mem[jn];
    end
  end else begin : g_one
    always_comb begin
      jn    = '0;
      cur_c = mem[0];
      nxt_c = mem[0];
    end
  end

  // Swap decision and end-of-pass / early-exit detection.
  always_comb begin
    swap_c = (state == SORT) && (mode ? (cur_c < nxt_c) : (cur_c > nxt_c));
    last_c = int'(j) >= int'(N) - 2 - int'(i);
    fin_c  = last_c && (!(flag || swap_c) || (int'(i) == int'(N) - 2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_c   = 1'b0;
    accept_c = 1'b0;
    case (state)
      IDLE: begin
        if (load_valid) begin
          load_c = 1'b1;
        end else if (start) begin
          accept_c = 1'b1;
          state_nx = (N == 1) ? DONE : SORT;
        end
      end
      SORT:    if (fin_c) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(N); k++) mem[k] <= '0;
      wr_ptr <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sorted <= 1'b0;
      i      <= '0;
      j      <= '0;
      mode   <= 1'b0;
      flag   <= 1'b0;
`ifdef BUBBLE_SORT_STATS_EN
      swap_count <= '0;
`endif
    end else begin
      busy <= (state_nx == SORT);
      done <= (state_nx == DONE);
      if (load_c) begin
        mem[wr_ptr] <= load_data;
        wr_ptr      <= (wr_ptr == PW'(N - 1)) ? '0 : wr_ptr + PW'(1);
        sorted      <= 1'b0;
      end
      if (accept_c) begin
        mode   <= descending;
        i      <= '0;
        j      <= '0;
        flag   <= 1'b0;
        wr_ptr <= '0;
        sorted <= 1'b0;
`ifdef BUBBLE_SORT_STATS_EN
        swap_count <= '0;
`endif
      end
      if (state == SORT) begin
        if (swap_c) begin
          mem[j]  <= nxt_c;
          mem[jn] <= cur_c;
`ifdef BUBBLE_SORT_STATS_EN
          swap_count <= swap_count + SW'(1);
`endif
        end
        if (!last_c) begin
          j    <= j + PW'(1);
          flag <= flag | swap_c;
        end else if (!fin_c) begin
          i    <= i + PW'(1);
          j    <= '0;
          flag <= 1'b0;
        end
      end
      if (state == DONE) sorted <= 1'b1;
    end
  end

  always_comb begin
    data_out = '0;
    for (int k = 0; k < int'(N); k++) data_out[k*W +: W] = mem[k];
  end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Directed bench for bubble_sort_engine at N=4, W=4.
module tb_bubble_sort_engine;
  localparam int unsigned N = 4;
  localparam int unsigned W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid, start, descending;
  logic [W-1:0] load_data;
  logic        busy, done, sorted;
  logic [1:0]  wr_ptr;
  logic [15:0] data_out;
`ifdef BUBBLE_SORT_STATS_EN
  logic [2:0]  swap_count;
`endif

  int total = 0;
  int bad   = 0;

  bubble_sort_engine #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .start(start), .descending(descending), .busy(busy), .done(done),
    .sorted(sorted), .wr_ptr(wr_ptr),
`ifdef BUBBLE_SORT_STATS_EN
    .swap_count(swap_count),
`endif
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pack(input int e0, e1, e2, e3);
    return {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
  endfunction

  task automatic load4(input int a, b, c, d);
    int v[4];
    v = '{a, b, c, d};
    foreach (v[k]) begin
      load_valid = 1'b1;
      load_data  = 4'(v[k]);
      step();
    end
    load_valid = 1'b0;
  endtask

  // Starts a sort and follows it to completion; descending toggles every cycle
  // and an optional start+load poke lands mid-sort, neither of which may matter.
  task automatic run_sort(input string tag, input logic d, input int exp_k,
                          input logic [15:0] exp_data, input int exp_sw, input int poke_k);
    int k;
    start = 1'b1;
    descending = d;
    step();
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 100) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      descending = ~descending;
      if (k == poke_k) begin
        start = 1'b1;
        load_valid = 1'b1;
        load_data = 4'hF;
      end
      step();
      start = 1'b0;
      load_valid = 1'b0;
      k++;
    end
    chk({tag, "_done_cycle"}, 32'(k), 32'(exp_k));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    step();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_sorted"}, 32'(sorted), 32'd1);
    chk({tag, "_data"}, 32'(data_out), 32'(exp_data));
    chk({tag, "_wr_ptr"}, 32'(wr_ptr), 32'd0);
`ifdef BUBBLE_SORT_STATS_EN
    chk({tag, "_swaps"}, 32'(swap_count), 32'(exp_sw));
`else
    if (exp_sw < 0) chk({tag, "_swaps"}, 32'(exp_sw), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    load_valid = 1'b0;
    start = 1'b0;
    descending = 1'b0;
    load_data = '0;
    step();
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sorted", 32'(sorted), 32'd0);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    rst = 1'b0;
    step();

    load4(9, 3, 7, 1);
    chk("load_data", 32'(data_out), 32'(pack(9, 3, 7, 1)));
    chk("load_wr_ptr", 32'(wr_ptr), 32'd0);
    run_sort("asc_mixed", 1'b0, 7, pack(1, 3, 7, 9), 5, 0);

    load4(1, 2, 3, 4);
    chk("load_clears_sorted", 32'(sorted), 32'd0);
    run_sort("asc_presorted", 1'b0, 4, pack(1, 2, 3, 4), 0, 0);

    load4(1, 2, 3, 4);
    run_sort("desc", 1'b1, 7, pack(4, 3, 2, 1), 6, 0);

    load4(5, 5, 2, 5);
    run_sort("asc_dups", 1'b0, 7, pack(2, 5, 5, 5), 2, 0);

    load4(1, 1, 1, 1);
    run_sort("all_equal", 1'b0, 4, pack(1, 1, 1, 1), 0, 0);

    // Five loads wrap the pointer; the fifth overwrites entry 0.
    load4(8, 6, 4, 2);
    load_valid = 1'b1;
    load_data = 4'd3;
    step();
    load_valid = 1'b0;
    chk("wrap_wr_ptr", 32'(wr_ptr), 32'd1);
    chk("wrap_data", 32'(data_out), 32'(pack(3, 6, 4, 2)));

    // Start with a simultaneous load: load wins, no sort.
    load_valid = 1'b1;
    start = 1'b1;
    load_data = 4'd9;
    step();
    load_valid = 1'b0;
    start = 1'b0;
    chk("start_load_busy", 32'(busy), 32'd0);
    chk("start_load_wr_ptr", 32'(wr_ptr), 32'd2);
    chk("start_load_data", 32'(data_out), 32'(pack(3, 9, 4, 2)));
    step();
    chk("start_load_still_idle", 32'(busy), 32'd0);
    run_sort("poke_mid_sort", 1'b0, 7, pack(2, 3, 4, 9), 4, 2);

    // Async reset in the middle of a sort.
    load4(9, 3, 7, 1);
    start = 1'b1;
    descending = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_data", 32'(data_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sorted", 32'(sorted), 32'd0);
    chk("midrst_wr_ptr", 32'(wr_ptr), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    load4(4, 1, 3, 2);
    run_sort("after_rst", 1'b0, 7, pack(1, 2, 3, 4), 4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bubble_sort_engine.md
Name: bubble_sort_engine

Overview:
- Parametrised in-place bubble sorter holding N entries of W bits each.
- Entries are loaded serially, sorted on a start pulse in ascending or descending order, and presented as a flat array for display or downstream logic.
- One compare/swap per cycle, with early exit after any pass that makes no swaps.
- Successor to the fixed 4×4-bit sort datapath; feeds the per-digit hex decoders.

Parameters:
N, 4, number of entries (N >= 1)
W, 4, entry width in bits (W >= 1)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
load_valid  input  1  write load_data into entry wr_ptr this cycle (IDLE only)
load_data  input  W  value to load
start  input  1  single-cycle request to begin sorting (IDLE only)
descending  input  1  order select, sampled when start is accepted: 0 ascending, 1 descending
busy  output  1  high while in SORT
done  output  1  one-cycle pulse when sorting completes
sorted  output  1  level; array valid and sorted since last completion
wr_ptr  output  clog2(N) (min 1)  next entry to be loaded
data_out  output  N*W  entry k at data_out[k*W +: W]

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: all entries 0, wr_ptr 0, state IDLE, busy 0, done 0, sorted 0, pass/index counters 0.
- States: IDLE, SORT, DONE.
- IDLE:
  - load_valid: entry[wr_ptr] <= load_data. wr_ptr increments and wraps from N-1 to 0. sorted <= 0.
  - start with load_valid low: latch descending into a mode register, clear pass counter i, index j and the pass-swap flag. Set wr_ptr <= 0, sorted <= 0, go to SORT.
  - start and load_valid in the same cycle: the load is performed and start is ignored.
- SORT (busy = 1):
  - Each cycle compares entry[j] and entry[j+1].
  - Swap when entry[j] > entry[j+1] (ascending) or entry[j] < entry[j+1] (descending). Unsigned compare.
  - Equal values never swap, so the sort is stable.
  - If j < N-2-i: j <= j+1.
  - Else the pass ends:
    - DONE if no swap occurred during the pass (including this cycle), or if i = N-2.
    - Otherwise i <= i+1, j <= 0, and the pass-swap flag is cleared.
- DONE: done = 1 for exactly one cycle, sorted <= 1, busy = 0. Next state IDLE.
- N = 1: start goes directly to DONE; no compares.
- Latency (start sampled in cycle t, first compare in t+1, done high in cycle t+C+1, where C = compares executed):
  - Best case: C = N-1.
  - Worst case: C = N(N-1)/2.
- Ignored inputs:
  - load_valid and start are ignored in SORT and DONE.
  - A change on descending mid-sort has no effect.
- rst asserted mid-sort: immediate return to reset values; the partially sorted contents are discarded.
- data_out is registered and reflects the array every cycle, including intermediate swaps during SORT.

Optional Feature:
BUBBLE_SORT_STATS_EN
- Defined:
  - Adds output swap_count, width clog2(N(N-1)/2+1).
  - Reset to 0; cleared when start is accepted; increments by 1 on each swap.
  - Holds its value after done until the next start or rst.
- Not defined: the swap_count port and its logic are absent. All other behaviour is identical.

Test Plan:
- N=4, W=4: load 9,3,7,1, start at t ascending -> data_out entries 1,3,7,9; busy t+1..t+6; done pulse at t+7 only; sorted=1 from t+8; swap_count=5.
- Load 1,2,3,4, start ascending -> early exit after one pass: done at t+4, contents unchanged, swap_count=0.
- Load 1,2,3,4, start with descending=1 -> entries 4,3,2,1; done at t+7; swap_count=6. Toggling descending during SORT changes nothing.
- Load 5,5,2,5 ascending -> entries 2,5,5,5; done at t+7; swap_count=2. Load 1,1,1,1 -> done at t+4, no swaps.
- Load five values 8,6,4,2,3 -> entry0=3, wr_ptr wraps to 1. Start plus load_valid in the same IDLE cycle -> load performed, busy stays 0. start pulse during SORT -> ignored; no restart.
- Load 9,3,7,1, start, assert rst at t+3 -> same cycle: data_out all 0, busy 0, done 0, sorted 0, wr_ptr 0. After release, new load/sort completes normally.
